wb_std_to_pipelined_bridge: RTL and testbench

Wishbone B4 bridge that accepts classic (standard) single-access cycles from an upstream standard master and re-issues them as pipelined-mode cycles to a downstream pipelined slave (e.g. `wb_slave_pipelined_wrapper`). It handles `stall` backpressure, holds `cyc` until the pipelined response returns, and converts the response into a single-cycle standard `ack`/`err`. One transaction is outstanding at a time. An optional watchdog terminates hung cycles.

---
 rtl/wb_std_to_pipelined_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_wb_std_to_pipelined_bridge.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_std_to_pipelined_bridge.sv
// Purpose : Wishbone B4 bridge that turns classic single-access cycles from an upstream master
//           into pipelined-mode cycles for a downstream slave, one transaction in flight at a time.
// Latency : request sampled at E0, downstream strobe after E0, upstream ack/err registered one edge
//           after the downstream response; at least 4 clocks between back-to-back requests.
// Backpressure: m_stall holds m_stb and the captured request; upstream waits with cyc/stb held.
// Optional: define WB_BRIDGE_TIMEOUT_EN to add a watchdog that errors out hung cycles after
//           timeout_cycles clocks. Without it the bridge waits indefinitely.
// Ports   : clk, rst (sync, active-high)
//           upstream   s_cyc, s_stb, s_we, s_adr, s_dat_i -> s_dat_o, s_ack, s_err
//           downstream m_cyc, m_stb, m_we, m_adr, m_dat_o -> m_dat_i, m_ack, m_err, m_stall
module wb_std_to_pipelined_bridge #(
  parameter int adr_width      = 16,
  parameter int dat_width      = 16,
  parameter int timeout_cycles = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_cyc,
  input  logic                 s_stb,
  input  logic                 s_we,
  input  logic [adr_width-1:0] s_adr,
  input  logic [dat_width-1:0] s_dat_i,
  output logic [dat_width-1:0] s_dat_o,
  output logic                 s_ack,
  output logic                 s_err,
  output logic                 m_cyc,
  output logic                 m_stb,
  output logic                 m_we,
  output logic [adr_width-1:0] m_adr,
  output logic [dat_width-1:0] m_dat_o,
  input  logic [dat_width-1:0] m_dat_i,
  input  logic                 m_ack,
  input  logic                 m_err,
  input  logic                 m_stall
);

  if (timeout_cycles < 1 || timeout_cycles > 65535) begin : g_bad_timeout
    $error("timeout_cycles must be within 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_s_ack;
  logic                 r_s_err;
  logic [dat_width-1:0] r_s_dat_o;
  logic                 r_m_cyc;
  logic                 r_m_stb;
  logic                 r_m_we;
  logic [adr_width-1:0] r_m_adr;
  logic [dat_width-1:0] r_m_dat_o;

  logic                 w_s_ack_nxt;
  logic                 w_s_err_nxt;
  logic [dat_width-1:0] w_s_dat_o_nxt;
  logic                 w_m_cyc_nxt;
  logic                 w_m_stb_nxt;
  logic                 w_m_we_nxt;
  logic [adr_width-1:0] w_m_adr_nxt;
  logic [dat_width-1:0] w_m_dat_o_nxt;

  logic w_req;
  logic w_busy;
  logic w_expire;

  assign w_req  = s_cyc & s_stb;
  assign w_busy = (r_state == ST_REQ) || (r_state == ST_WAIT);

`ifdef WB_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

  logic [15:0] r_wdog;

  // Counts edges spent in REQ/WAIT; the edge that would bring it to
  // timeout_cycles is the expiry edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (r_state == ST_IDLE) begin
      r_wdog <= '0;
    end else if (w_busy) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end

  assign w_expire = w_busy && (r_wdog == TMO_LAST);
`else
  assign w_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. Abort beats everything; a real response beats expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (!s_cyc)          w_state_nxt = ST_IDLE;
        else if (w_expire)   w_state_nxt = ST_RESP;
        else if (!m_stall)   w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!s_cyc)                          w_state_nxt = ST_IDLE;
        else if (m_ack || m_err || w_expire) w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_s_ack_nxt   = 1'b0;
    w_s_err_nxt   = 1'b0;
    w_s_dat_o_nxt = r_s_dat_o;
    w_m_cyc_nxt   = r_m_cyc;
    w_m_stb_nxt   = r_m_stb;
    w_m_we_nxt    = r_m_we;
    w_m_adr_nxt   = r_m_adr;
    w_m_dat_o_nxt = r_m_dat_o;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_m_we_nxt    = s_we;
          w_m_adr_nxt   = s_adr;
          w_m_dat_o_nxt = s_dat_i;
          w_m_cyc_nxt   = 1'b1;
          w_m_stb_nxt   = 1'b1;
        end
      end
      ST_REQ: begin
        // Any m_ack/m_err here is a slave protocol violation and is ignored.
        if (!s_cyc) begin
          w_m_cyc_nxt = 1'b0;
          w_m_stb_nxt = 1'b0;
        end else if (w_expire) begin
          w_s_err_nxt = 1'b1;
          w_m_cyc_nxt = 1'b0;
          w_m_stb_nxt = 1'b0;
        end else if (!m_stall) begin
          w_m_stb_nxt = 1'b0;
        end
      end
      ST_WAIT: begin
        if (!s_cyc) begin
          w_m_cyc_nxt = 1'b0;
        end else if (m_err) begin
          // Error wins over a simultaneous ack.
          w_s_err_nxt = 1'b1;
          w_m_cyc_nxt = 1'b0;
        end else if (m_ack) begin
          w_s_ack_nxt = 1'b1;
          w_m_cyc_nxt = 1'b0;
          if (!r_m_we) w_s_dat_o_nxt = m_dat_i;
        end else if (w_expire) begin
          w_s_err_nxt = 1'b1;
          w_m_cyc_nxt = 1'b0;
        end
      end
      default: ;  // RESP: ack/err fall back to 0, upstream not sampled
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_ack   <= 1'b0;
      r_s_err   <= 1'b0;
      r_s_dat_o <= '0;
      r_m_cyc   <= 1'b0;
      r_m_stb   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_adr   <= '0;
      r_m_dat_o <= '0;
    end else begin
      r_s_ack   <= w_s_ack_nxt;
      r_s_err   <= w_s_err_nxt;
      r_s_dat_o <= w_s_dat_o_nxt;
      r_m_cyc   <= w_m_cyc_nxt;
      r_m_stb   <= w_m_stb_nxt;
      r_m_we    <= w_m_we_nxt;
      r_m_adr   <= w_m_adr_nxt;
      r_m_dat_o <= w_m_dat_o_nxt;
    end
  end

  assign s_ack   = r_s_ack;
  assign s_err   = r_s_err;
  assign s_dat_o = r_s_dat_o;
  assign m_cyc   = r_m_cyc;
  assign m_stb   = r_m_stb;
  assign m_we    = r_m_we;
  assign m_adr   = r_m_adr;
  assign m_dat_o = r_m_dat_o;

endmodule

// File: tb/tb_wb_std_to_pipelined_bridge.sv
// Self-checking bench for wb_std_to_pipelined_bridge: directed cases plus randomized
// transactions against a transaction-level memory/response model.
module tb_wb_std_to_pipelined_bridge;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_i, s_dat_o;
  logic          s_ack, s_err;
  logic          m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat_o, m_dat_i;
  logic          m_ack, m_err, m_stall;

  always #5 clk = ~clk;

  wb_std_to_pipelined_bridge #(
    .adr_width(AW), .dat_width(DW), .timeout_cycles(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_i(s_dat_i),
    .s_dat_o(s_dat_o), .s_ack(s_ack), .s_err(s_err),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_o(m_dat_o),
    .m_dat_i(m_dat_i), .m_ack(m_ack), .m_err(m_err), .m_stall(m_stall)
  );

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;   // downstream requests actually accepted (monitor)
  int exp_acc  = 0;   // accepted requests the model expects

  logic [DW-1:0] ref_mem [32];  // model of slave contents seen from upstream
  logic [DW-1:0] slv_mem [32];  // the slave's own storage, written from m_* signals
  logic [DW-1:0] exp_dat_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && m_cyc && m_stb && !m_stall) acc_cnt <= acc_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_mcyc"}, 32'(m_cyc), 32'd0);
    chk({tag, "_mstb"}, 32'(m_stb), 32'd0);
    chk({tag, "_sack"}, 32'(s_ack), 32'd0);
    chk({tag, "_serr"}, 32'(s_err), 32'd0);
  endtask

  // kind: 0 = ack, 1 = err, 2 = ack and err together
  task automatic do_txn(input logic we, input logic [4:0] adr, input logic [DW-1:0] dat,
                        input int nstall, input int ndelay, input int kind, input bit hold,
                        input string tag);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = {11'd0, adr}; s_dat_i = dat;
    m_ack = 1'b0; m_err = 1'b0; m_stall = 1'b0;
    step();  // E0: request sampled
    chk({tag, "_cyc0"}, 32'(m_cyc), 32'd1);
    chk({tag, "_stb0"}, 32'(m_stb), 32'd1);
    chk({tag, "_adr"},  32'(m_adr), 32'(adr));
    chk({tag, "_we"},   32'(m_we),  32'(we));
    chk({tag, "_wdat"}, 32'(m_dat_o), 32'(dat));
    for (int i = 0; i < nstall; i++) begin
      m_stall = 1'b1;
      m_ack = 1'($urandom_range(0, 1));  // stray responses before acceptance
      m_err = 1'($urandom_range(0, 1));
      step();
      chk({tag, "_stb_stall"}, 32'(m_stb), 32'd1);
      chk({tag, "_adr_stall"}, 32'(m_adr), 32'(adr));
      chk({tag, "_ack_stall"}, 32'(s_ack | s_err), 32'd0);
    end
    m_stall = 1'b0;
    m_ack = 1'($urandom_range(0, 1));
    m_err = 1'($urandom_range(0, 1));
    step();  // acceptance edge
    exp_acc++;
    chk({tag, "_stb_acc"}, 32'(m_stb), 32'd0);
    chk({tag, "_cyc_acc"}, 32'(m_cyc), 32'd1);
    chk({tag, "_rsp_acc"}, 32'(s_ack | s_err), 32'd0);
    m_ack = 1'b0; m_err = 1'b0;
    for (int i = 0; i < ndelay; i++) begin
      m_stall = 1'($urandom_range(0, 1));
      step();
      chk({tag, "_cyc_wait"}, 32'(m_cyc), 32'd1);
      chk({tag, "_rsp_wait"}, 32'(s_ack | s_err), 32'd0);
    end
    // Slave response driven from what the slave sees on m_*
    m_ack = (kind != 1);
    m_err = (kind != 0);
    m_dat_i = m_we ? DW'($urandom) : slv_mem[m_adr[4:0]];
    if (kind == 0 && m_we) slv_mem[m_adr[4:0]] = m_dat_o;
    if (kind == 0) begin
      if (we) ref_mem[adr] = dat;
      else    exp_dat_o = ref_mem[adr];
    end
    step();  // response edge
    chk({tag, "_sack"}, 32'(s_ack), 32'(kind == 0));
    chk({tag, "_serr"}, 32'(s_err), 32'(kind != 0));
    chk({tag, "_cyc_end"}, 32'(m_cyc), 32'd0);
    chk({tag, "_rdat"}, 32'(s_dat_o), 32'(exp_dat_o));
    m_ack = 1'b0; m_err = 1'b0;
    if (!hold) begin
      s_cyc = 1'b0; s_stb = 1'b0;
    end
    step();  // RESP -> IDLE; upstream must not be sampled here
    chk_idle_outs({tag, "_post"});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit");
  end

  initial begin
    int r, kind;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = DW'(100 + i);
      slv_mem[i] = DW'(100 + i);
    end
    exp_dat_o = '0;
    rst = 1'b1; s_cyc = 0; s_stb = 0; s_we = 0; s_adr = '0; s_dat_i = '0;
    m_dat_i = '0; m_ack = 0; m_err = 0; m_stall = 0;
    step(); step();
    chk_idle_outs("reset");
    chk("reset_adr", 32'(m_adr), 32'd0);
    chk("reset_dato", 32'(s_dat_o), 32'd0);
    rst = 1'b0;
    step();

    do_txn(1'b1, 5'd1, 16'd101, 0, 0, 0, 1'b0, "wr_nostall");
    do_txn(1'b0, 5'd5, 16'd0,   2, 0, 0, 1'b0, "rd_stall");
    chk("rd_stall_val", 32'(s_dat_o), 32'd105);

    for (int i = 0; i < 10; i++) do_txn(1'b1, 5'(11 + i), 16'(211 + i), 0, 0, 0, 1'b1, "b2b_wr");
    for (int i = 0; i < 10; i++) begin
      do_txn(1'b0, 5'(11 + i), 16'd0, 0, 0, 0, 1'b1, "b2b_rd");
      chk("b2b_rd_val", 32'(s_dat_o), 32'(211 + i));
    end
    s_cyc = 0; s_stb = 0;
    step();
    chk("b2b_count", 32'(acc_cnt), 32'(exp_acc));

    do_txn(1'b0, 5'd7, 16'd0, 0, 1, 1, 1'b0, "err");
    do_txn(1'b0, 5'd8, 16'd0, 1, 0, 2, 1'b0, "ack_err");

    // Abort in WAIT, then a late ack arrives while idle
    s_cyc = 1; s_stb = 1; s_we = 0; s_adr = 16'd3; m_stall = 0;
    step(); step(); exp_acc++;
    s_cyc = 0; s_stb = 0;
    step();
    chk_idle_outs("abort_wait");
    m_ack = 1; m_dat_i = 16'hdead;
    step();
    chk_idle_outs("abort_late");
    chk("abort_dato", 32'(s_dat_o), 32'(exp_dat_o));
    m_ack = 0;
    step();

    // Abort in REQ while stalled
    s_cyc = 1; s_stb = 1; s_we = 1; s_adr = 16'd4; m_stall = 1;
    step();
    s_cyc = 0; s_stb = 0;
    step();
    chk_idle_outs("abort_req");
    m_stall = 0;

    // Reset while in REQ
    s_cyc = 1; s_stb = 1; s_we = 1; s_adr = 16'd9; s_dat_i = 16'h1234; m_stall = 1;
    step();
    rst = 1;
    step();
    chk_idle_outs("rst_req");
    chk("rst_req_adr", 32'(m_adr), 32'd0);
    chk("rst_req_dat", 32'(m_dat_o), 32'd0);
    chk("rst_req_we", 32'(m_we), 32'd0);
    chk("rst_req_dato", 32'(s_dat_o), 32'd0);
    exp_dat_o = '0;
    rst = 0; s_cyc = 0; s_stb = 0; m_stall = 0;
    step();

`ifdef WB_BRIDGE_TIMEOUT_EN
    // Slave never answers: error 8 edges after entering REQ
    s_cyc = 1; s_stb = 1; s_we = 0; s_adr = 16'd6; m_stall = 0;
    step(); exp_acc++;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("tmo_err", 32'(s_err), 32'(i == 8));
      chk("tmo_cyc", 32'(m_cyc), 32'(i < 8));
      chk("tmo_ack", 32'(s_ack), 32'd0);
    end
    s_cyc = 0; s_stb = 0;
    step();
    chk_idle_outs("tmo_post");
    do_txn(1'b0, 5'd6, 16'd0, 1, 1, 0, 1'b0, "tmo_next");
`endif

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 15);
      kind = (r == 0) ? 2 : (r < 3) ? 1 : 0;
      do_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), DW'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), kind, 1'($urandom_range(0, 1)),
             "rand");
    end
    s_cyc = 0; s_stb = 0;
    step();
    chk("final_count", 32'(acc_cnt), 32'(exp_acc));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
